// File: rtl/mem_stage_pkg.sv
// Shared decode for the memory-access stage: opcodes, FSM states, byte-enable
// patterns and load/store classification.
package mem_stage_pkg;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   function automatic logic is_load(input logic [5:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      case (op)
         OP_SB, OP_SH, OP_SW: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

   function automatic size_t access_size(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW:          return SZ_WORD;
         OP_LH, OP_LHU, OP_SH:  return SZ_HALF;
         default:               return SZ_BYTE;
      endcase
   endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/half of a loaded word and sign- or zero-extends it.
module load_formatter
   import mem_stage_pkg::*;
(
   input  logic [31:0] load_buf,
   input  logic [1:0]  addr,
   input  logic [5:0]  opcode,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel  = load_buf[{addr, 3'b000} +: 8];
      half_sel  = addr[1] ? load_buf[31:16] : load_buf[15:0];
      load_data = load_buf;
      case (opcode)
         OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_data = {24'h000000, byte_sel};
         OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_data = {16'h0000, half_sel};
         default: load_data = load_buf;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: load/store over a req/ack bus with stall and timeout.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses skip the bus and raise align_err.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [5:0]  opcode_in,
   input  logic [31:0] alu_out_in,
   input  logic [31:0] rdata2_in,
   input  logic [4:0]  rd_in,
   output logic        stall,
   output logic [31:0] result_out,
   output logic [4:0]  rd_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        bus_err,
   output logic        align_err
);

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q;
   logic [31:0] load_buf_q, addr_q, wdata_q, alu_q;
   logic [3:0]  be_q;
   logic        we_q, bus_err_q, align_err_q;
   logic [5:0]  op_q;
   logic [4:0]  rd_q;

   logic        mem_op, misaligned, timeout;
   size_t       size_new;
   logic [3:0]  be_new;
   logic [31:0] wdata_new, fmt_data;

   load_formatter u_fmt (
      .load_buf  (load_buf_q),
      .addr      (alu_q[1:0]),
      .opcode    (op_q),
      .load_data (fmt_data)
   );

   always_comb begin
      mem_op   = in_valid && (is_load(opcode_in) || is_store(opcode_in));
      size_new = access_size(opcode_in);
      timeout  = (wait_cnt_q == 8'(TIMEOUT_CYC));
      case (size_new)
         SZ_BYTE: begin
            be_new    = BE_BYTE0 << alu_out_in[1:0];
            wdata_new = {4{rdata2_in[7:0]}};
         end
         SZ_HALF: begin
            be_new    = alu_out_in[1] ? BE_HALF_HI : BE_HALF_LO;
            wdata_new = {2{rdata2_in[15:0]}};
         end
         default: begin
            be_new    = BE_WORD;
            wdata_new = rdata2_in;
         end
      endcase
`ifdef MEM_ALIGN_CHECK_EN
      misaligned = ((size_new == SZ_HALF) && alu_out_in[0]) ||
                   ((size_new == SZ_WORD) && (alu_out_in[1:0] != 2'b00));
`else
      misaligned = 1'b0;
`endif
   end

   always_comb begin
      state_d    = state_q;
      stall      = 1'b0;
      dmem_req   = 1'b0;
      result_out = alu_out_in;
      rd_out     = rd_in;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               stall   = 1'b1;
               state_d = misaligned ? DONE : REQ;
            end
         end
         REQ: begin
            stall    = 1'b1;
            dmem_req = 1'b1;
            if (dmem_ack || timeout) state_d = DONE;
         end
         DONE: begin
            state_d    = IDLE;
            rd_out     = rd_q;
            result_out = align_err_q ? '0 : (is_load(op_q) ? fmt_data : alu_q);
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus outputs are only meaningful while a request is outstanding.
   assign dmem_we    = dmem_req & we_q;
   assign dmem_addr  = dmem_req ? addr_q  : '0;
   assign dmem_wdata = dmem_req ? wdata_q : '0;
   assign dmem_be    = dmem_req ? be_q    : '0;
   assign bus_err    = (state_q == DONE) & bus_err_q;
`ifdef MEM_ALIGN_CHECK_EN
   assign align_err  = (state_q == DONE) & align_err_q;
`else
   assign align_err  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         load_buf_q  <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         alu_q       <= '0;
         be_q        <= '0;
         we_q        <= 1'b0;
         op_q        <= '0;
         rd_q        <= '0;
         bus_err_q   <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && mem_op) begin
            op_q        <= opcode_in;
            rd_q        <= rd_in;
            alu_q       <= alu_out_in;
            addr_q      <= {alu_out_in[31:2], 2'b00};
            wdata_q     <= wdata_new;
            be_q        <= be_new;
            we_q        <= is_store(opcode_in);
            wait_cnt_q  <= '0;
            load_buf_q  <= '0;
            bus_err_q   <= 1'b0;
            align_err_q <= misaligned;
         end else if (state_q == REQ) begin
            // Ack takes priority over a timeout in the same cycle.
            if (dmem_ack) begin
               load_buf_q <= dmem_rdata;
            end else if (timeout) begin
               bus_err_q  <= 1'b1;
               load_buf_q <= '0;
            end else if (wait_cnt_q != 8'hFF) begin
               wait_cnt_q <= wait_cnt_q + 8'd1;
            end
         end else if (state_q == DONE) begin
            bus_err_q   <= 1'b0;
            align_err_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed + randomized checks of mem_access_stage against an arithmetic reference model.
module tb_mem_access_stage;

   localparam int TOUT = 4;

   localparam logic [5:0] LB  = 6'b100000, LH  = 6'b100001, LW = 6'b100011;
   localparam logic [5:0] LBU = 6'b100100, LHU = 6'b100101;
   localparam logic [5:0] SB  = 6'b101000, SH  = 6'b101001, SW = 6'b101011;

   logic        clk = 1'b0, rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [5:0]  opcode_in = '0;
   logic [31:0] alu_out_in = '0, rdata2_in = '0, dmem_rdata = '0;
   logic [4:0]  rd_in = '0;
   logic        dmem_ack = 1'b0;
   logic        stall, dmem_req, dmem_we, bus_err, align_err;
   logic [31:0] result_out, dmem_addr, dmem_wdata;
   logic [4:0]  rd_out;
   logic [3:0]  dmem_be;

   int n_vec = 0;
   int n_err = 0;

   mem_access_stage #(.TIMEOUT_CYC(TOUT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .opcode_in(opcode_in),
      .alu_out_in(alu_out_in), .rdata2_in(rdata2_in), .rd_in(rd_in),
      .stall(stall), .result_out(result_out), .rd_out(rd_out),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .bus_err(bus_err), .align_err(align_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int ref_size(input logic [5:0] op);
      if (op == LW || op == SW) return 4;
      if (op == LH || op == LHU || op == SH) return 2;
      return 1;
   endfunction

   function automatic bit ref_is_load(input logic [5:0] op);
      return op == LB || op == LH || op == LW || op == LBU || op == LHU;
   endfunction

   function automatic bit ref_is_mem(input logic [5:0] op);
      return ref_is_load(op) || op == SB || op == SH || op == SW;
   endfunction

   function automatic int ref_off(input logic [5:0] op, input logic [31:0] addr);
      return int'(addr[1:0]) & (4 - ref_size(op));
   endfunction

   function automatic logic [3:0] ref_be(input logic [5:0] op, input logic [31:0] addr);
      return 4'(((1 << ref_size(op)) - 1) << ref_off(op, addr));
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [5:0] op, input logic [31:0] d);
      case (ref_size(op))
         1:       return {24'h0, d[7:0]} * 32'h01010101;
         2:       return {16'h0, d[15:0]} * 32'h00010001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                            input logic [31:0] w);
      int          s;
      logic [31:0] v, mask;
      s    = ref_size(op);
      v    = w >> (8 * ref_off(op, addr));
      mask = (s == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * s)) - 32'd1);
      v    = v & mask;
      if ((op == LB || op == LH) && v[8*s-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic bit ref_misaligned(input logic [5:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
      return (int'(addr[1:0]) % ref_size(op)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   // waits: number of REQ cycles before ack; negative or > TOUT means no ack.
   task automatic mem_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int waits);
      logic [4:0]  rd;
      logic [31:0] exp_res;
      bit          ld, mis, to;
      int          nreq;
      rd      = 5'($urandom);
      ld      = ref_is_load(op);
      mis     = ref_misaligned(op, addr);
      to      = !mis && (waits < 0 || waits > TOUT);
      nreq    = mis ? 0 : (to ? TOUT + 1 : waits + 1);
      exp_res = mis ? 32'h0 : (ld ? (to ? 32'h0 : ref_load(op, addr, rdata)) : addr);

      @(posedge clk); #1;
      in_valid = 1'b1; opcode_in = op; alu_out_in = addr; rdata2_in = sdata; rd_in = rd;
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      #1;
      chk("issue_stall", 32'(stall), 32'd1);
      chk("issue_req", 32'(dmem_req), 32'd0);

      for (int i = 0; i < nreq; i++) begin
         @(posedge clk); #1;
         alu_out_in = $urandom; rdata2_in = $urandom; rd_in = 5'($urandom);
         dmem_ack   = !to && (i == waits);
         dmem_rdata = dmem_ack ? rdata : $urandom;
         #1;
         chk("req", 32'(dmem_req), 32'd1);
         chk("req_stall", 32'(stall), 32'd1);
         chk("we", 32'(dmem_we), 32'(!ld));
         chk("addr", dmem_addr, {addr[31:2], 2'b00});
         chk("be", 32'(dmem_be), 32'(ref_be(op, addr)));
         if (!ld) chk("wdata", dmem_wdata, ref_wdata(op, sdata));
         chk("req_bus_err", 32'(bus_err), 32'd0);
      end

      @(posedge clk); #1;
      dmem_ack = 1'($urandom); dmem_rdata = $urandom;
      #1;
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_req", 32'(dmem_req), 32'd0);
      chk("result", result_out, exp_res);
      chk("rd_out", 32'(rd_out), 32'(rd));
      chk("bus_err", 32'(bus_err), 32'(to));
      chk("align_err", 32'(align_err), 32'(mis));
   endtask

   task automatic pass_thru(input bit vld, input logic [5:0] op, input logic [31:0] alu);
      logic [4:0] rd;
      rd = 5'($urandom);
      @(posedge clk); #1;
      in_valid = vld; opcode_in = op; alu_out_in = alu; rdata2_in = $urandom; rd_in = rd;
      dmem_ack = 1'($urandom);
      #1;
      chk("pt_result", result_out, alu);
      chk("pt_rd", 32'(rd_out), 32'(rd));
      chk("pt_stall", 32'(stall), 32'd0);
      chk("pt_req", 32'(dmem_req), 32'd0);
      chk("pt_bus_err", 32'(bus_err), 32'd0);
   endtask

   logic [5:0] op_tab [11];

   initial begin
      op_tab = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'b000000, 6'b100010, 6'b101100};

      #2 rst = 1'b1;
      #2;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_we", 32'(dmem_we), 32'd0);
      chk("rst_be", 32'(dmem_be), 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_wdata", dmem_wdata, 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_align_err", 32'(align_err), 32'd0);
      chk("rst_result", result_out, 32'd0);
      @(negedge clk) rst = 1'b0;

      pass_thru(1'b1, 6'b000000, 32'h00001234);
      mem_txn(SB, 32'h00001003, 32'h000000AB, 32'h0, 0);
      mem_txn(LB, 32'h00002001, 32'h000080FF, 32'h0, 3);
      mem_txn(LHU, 32'h00002002, 32'h0, 32'hBEEF0000, 1);
      mem_txn(LW, 32'h00002004, 32'h0, 32'h0, -1);
      pass_thru(1'b0, LW, 32'hCAFE0000);
      mem_txn(LH, 32'h00000006, 32'h0, 32'h8001_7FFF, TOUT);
      mem_txn(SH, 32'h00000012, 32'h1234ABCD, 32'h0, 2);
      mem_txn(SW, 32'h00003002, 32'hDEADBEEF, 32'h0, 0);
      mem_txn(LW, 32'h00003001, 32'h0, 32'h11223344, 0);
      mem_txn(LHU, 32'h00003003, 32'h0, 32'h89ABCDEF, 0);

      for (int n = 0; n < 40; n++) begin
         logic [5:0]  op;
         logic [31:0] a;
         op = op_tab[$urandom_range(0, 10)];
         a  = $urandom;
         if (ref_is_mem(op))
            mem_txn(op, a, $urandom, $urandom, int'($urandom_range(0, TOUT + 1)));
         else
            pass_thru(1'($urandom), op, a);
      end

      @(posedge clk); #1;
      in_valid = 1'b1; opcode_in = LW; alu_out_in = 32'h00000040; dmem_ack = 1'b0;
      @(posedge clk); #1;
      #1 chk("mid_req", 32'(dmem_req), 32'd1);
      #2 rst = 1'b1; in_valid = 1'b0;
      #1;
      chk("mid_rst_req", 32'(dmem_req), 32'd0);
      chk("mid_rst_stall", 32'(stall), 32'd0);
      @(negedge clk) rst = 1'b0;
      pass_thru(1'b1, 6'b000000, 32'h00000077);
      mem_txn(LBU, 32'h00000043, 32'h0, 32'hF0E0D0C0, 0);

      @(posedge clk); #1;
      in_valid = 1'b0; dmem_ack = 1'b0;
      #1 chk("final_stall", 32'(stall), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
